// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter: arbiter FSM states, owner tags,
// full-word write mask and a saturating counter helper.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN_I = 2'd1,
      ARB_OWN_D = 2'd2
   } lc3b_arb_state;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } lc3b_arb_owner;

   localparam lc3b_mem_wmask LC3B_WMASK_ALL = 2'b11;

   // 4-bit increment that sticks at 15 instead of wrapping
   function automatic logic [3:0] sat_inc4(input logic [3:0] value);
      return (value == 4'hF) ? value : value + 4'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational owner selection for mem_arbiter.
// Default build: fixed D priority with a starvation limit that forces I through.
// Build option ARB_RR_EN: strict alternation on contention using last_owner.
module arb_pick
   import lc3b_types::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          i_req,
   input  logic          d_req,
   input  logic [3:0]    starve_cnt,
   input  lc3b_arb_owner last_owner,
   output logic          grant_i,
   output logic          grant_d
);

`ifdef ARB_RR_EN
   // Counter and limit have no role when alternating; sink them quietly.
   logic unused_cfg;
   assign unused_cfg = ^{starve_cnt, 4'(STARVE_LIMIT)};

   // On contention the side that did not own the port last time wins.
   always_comb begin
      grant_i = i_req && (!d_req || (last_owner == OWNER_D));
      grant_d = d_req && !grant_i;
   end
`else
   // Alternation history is irrelevant under fixed priority.
   logic unused_cfg;
   assign unused_cfg = last_owner;

   logic starved;
   assign starved = (starve_cnt == 4'(STARVE_LIMIT));

   // D wins contention unless I has been passed over STARVE_LIMIT times.
   always_comb begin
      grant_d = d_req && !(i_req && starved);
      grant_i = i_req && !grant_d;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single LC-3b memory port between the I side and D side.
// One owner at a time; its handshake passes straight through, responses and
// read data are routed back only to the owner. Every transaction is separated
// by at least one IDLE cycle. Build option ARB_RR_EN selects round-robin picking.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [1:0]        d_wmask,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        mem_byte_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata
);

   lc3b_arb_state state_reg, state_next;
   lc3b_arb_owner last_owner_reg;
   logic [3:0]    starve_cnt;
   logic          d_req;
   logic          grant_i, grant_d;

   assign d_req = d_read | d_write;

   arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .i_req      (i_read),
      .d_req      (d_req),
      .starve_cnt (starve_cnt),
      .last_owner (last_owner_reg),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

   // State register plus record of who was granted last.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ARB_IDLE;
         last_owner_reg <= OWNER_I;
      end else begin
         state_reg <= state_next;
         if (state_reg == ARB_IDLE) begin
            if (grant_i) begin
               last_owner_reg <= OWNER_I;
            end else if (grant_d) begin
               last_owner_reg <= OWNER_D;
            end
         end
      end
   end

`ifdef ARB_RR_EN
   assign starve_cnt = 4'd0;
`else
   logic [3:0] starve_cnt_reg;
   assign starve_cnt = starve_cnt_reg;

   // Count D grants that passed over a waiting I; any I grant clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_reg <= 4'd0;
      end else if (state_reg == ARB_IDLE) begin
         if (grant_i) begin
            starve_cnt_reg <= 4'd0;
         end else if (grant_d && i_read) begin
            starve_cnt_reg <= sat_inc4(starve_cnt_reg);
         end
      end
   end
`endif

   // Next state and memory-side/requester-side output decode.
   always_comb begin
      state_next      = state_reg;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 2'b00;
      mem_address     = '0;
      mem_wdata       = '0;
      i_rdata         = '0;
      i_resp          = 1'b0;
      d_rdata         = '0;
      d_resp          = 1'b0;
      unique case (state_reg)
         ARB_IDLE: begin
            if (grant_i) begin
               state_next = ARB_OWN_I;
            end else if (grant_d) begin
               state_next = ARB_OWN_D;
            end
         end
         ARB_OWN_I: begin
            mem_read        = i_read;
            mem_byte_enable = LC3B_WMASK_ALL;
            mem_address     = i_address;
            i_rdata         = mem_rdata;
            if (!i_read) begin
               state_next = ARB_IDLE;
            end else if (mem_resp) begin
               i_resp     = 1'b1;
               state_next = ARB_IDLE;
            end
         end
         ARB_OWN_D: begin
            mem_read        = d_read;
            mem_write       = d_write;
            mem_byte_enable = d_wmask;
            mem_address     = d_address;
            mem_wdata       = d_wdata;
            d_rdata         = mem_rdata;
            if (!d_req) begin
               state_next = ARB_IDLE;
            end else if (mem_resp) begin
               d_resp     = 1'b1;
               state_next = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// directed sequences for contention, back-to-back, reset and abort cases.
module tb_mem_arbiter;

   localparam int ADDR_W       = 16;
   localparam int DATA_W       = 16;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [DATA_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [1:0]        d_wmask;
   logic [ADDR_W-1:0] d_address;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [1:0]        mem_byte_enable;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_resp;
   logic [DATA_W-1:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_read          (i_read),
      .i_address       (i_address),
      .i_rdata         (i_rdata),
      .i_resp          (i_resp),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_wmask         (d_wmask),
      .d_address       (d_address),
      .d_wdata         (d_wdata),
      .d_rdata         (d_rdata),
      .d_resp          (d_resp),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata)
   );

   typedef struct {
      string       name;
      logic        side_d;
      logic        wr;
      logic [1:0]  wmask;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;
      logic [1:0]  exp_be;
      logic [15:0] exp_wdata;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_read    = 1'b0;
      i_address = '0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      d_wmask   = 2'b00;
      d_address = '0;
      d_wdata   = '0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic reset_pulse();
      cyc();
      clear_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".strobes"}, {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
      chk({name, ".be"}, mem_byte_enable, 2'b00);
      chk({name, ".addr"}, mem_address, 16'h0000);
      chk({name, ".wdata"}, mem_wdata, 16'h0000);
      chk({name, ".rdata"}, {i_rdata, d_rdata}, 32'h0);
   endtask

   task automatic run_contention();
      logic exp_seq [0:9];
      int   n;
      int   got;
      logic owner_d;
`ifdef ARB_RR_EN
      n = 4;
      exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
      for (int k = 4; k < 10; k++) exp_seq[k] = 1'b0;
`else
      n = 10;
      for (int k = 0; k < 10; k++) exp_seq[k] = 1'b1;
      exp_seq[4] = 1'b0;
      exp_seq[9] = 1'b0;
`endif
      reset_pulse();
      cyc();
      i_read    = 1'b1;
      i_address = 16'h0040;
      d_read    = 1'b1;
      d_address = 16'h0200;
      mem_rdata = 16'hC0DE;
      got = 0;
      for (int c = 0; c < 80 && got < n; c++) begin
         cyc();
         mem_resp = 1'b0;
         #1;
         if (mem_read) begin
            owner_d = (mem_address == 16'h0200);
            chk($sformatf("grant[%0d]", got), owner_d, exp_seq[got]);
            mem_resp = 1'b1;
            #1;
            chk($sformatf("grant_resp[%0d]", got), {i_resp, d_resp}, {!owner_d, owner_d});
            $display("contention grant %0d -> %s", got, owner_d ? "D" : "I");
            got++;
         end
      end
      if (got < n) chk("contention_budget", got, n);
      cyc();
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"i_read_0040",  1'b0, 1'b0, 2'b00, 16'h0040, 16'hFFFF, 16'h1234, 3, 2'b11, 16'h0000};
      vecs[1] = '{"d_write_0101", 1'b1, 1'b1, 2'b10, 16'h0101, 16'hAB00, 16'h9999, 2, 2'b10, 16'hAB00};
      vecs[2] = '{"d_read_3000",  1'b1, 1'b0, 2'b11, 16'h3000, 16'h0000, 16'hBEEF, 1, 2'b11, 16'h0000};
      vecs[3] = '{"i_read_0ffe",  1'b0, 1'b0, 2'b00, 16'h0FFE, 16'h5A5A, 16'h8001, 1, 2'b11, 16'h0000};
      vecs[4] = '{"d_write_ffff", 1'b1, 1'b1, 2'b01, 16'hFFFF, 16'h00CD, 16'h0000, 4, 2'b01, 16'h00CD};

      // Reset state, including a stray mem_resp that must be ignored.
      clear_inputs();
      rst       = 1'b1;
      mem_resp  = 1'b1;
      mem_rdata = 16'h7777;
      cyc();
      cyc();
      chk_all_zero("reset");
      rst = 1'b0;
      cyc();
      chk_all_zero("idle_resp_ignored");
      clear_inputs();

      // Single transactions from the table.
      for (int v = 0; v < 5; v++) begin
         cyc();
         if (vecs[v].side_d) begin
            d_read    = !vecs[v].wr;
            d_write   = vecs[v].wr;
            d_wmask   = vecs[v].wmask;
            d_address = vecs[v].addr;
         end else begin
            i_read    = 1'b1;
            i_address = vecs[v].addr;
         end
         d_wdata   = vecs[v].wdata;
         mem_rdata = vecs[v].rdata;
         mem_resp  = 1'b0;
         #1;
         chk({vecs[v].name, ".idle"}, {mem_read, mem_write}, 2'b00);
         for (int k = 1; k <= vecs[v].lat; k++) begin
            cyc();
            mem_resp = (k == vecs[v].lat);
            #1;
            chk({vecs[v].name, ".mem_read"}, mem_read, vecs[v].side_d ? !vecs[v].wr : 1'b1);
            chk({vecs[v].name, ".mem_write"}, mem_write, vecs[v].side_d ? vecs[v].wr : 1'b0);
            chk({vecs[v].name, ".addr"}, mem_address, vecs[v].addr);
            chk({vecs[v].name, ".be"}, mem_byte_enable, vecs[v].exp_be);
            chk({vecs[v].name, ".wdata"}, mem_wdata, vecs[v].exp_wdata);
            chk({vecs[v].name, ".i_resp"}, i_resp, !vecs[v].side_d && (k == vecs[v].lat));
            chk({vecs[v].name, ".d_resp"}, d_resp, vecs[v].side_d && (k == vecs[v].lat));
            chk({vecs[v].name, ".i_rdata"}, i_rdata, vecs[v].side_d ? 16'h0000 : vecs[v].rdata);
            chk({vecs[v].name, ".d_rdata"}, d_rdata, vecs[v].side_d ? vecs[v].rdata : 16'h0000);
         end
         cyc();
         clear_inputs();
         #1;
         chk({vecs[v].name, ".after"}, {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
         $display("transaction %s side=%s addr=%h done", vecs[v].name,
                  vecs[v].side_d ? "D" : "I", vecs[v].addr);
      end

      // Both sides hammering the port.
      run_contention();

      // Back-to-back D writes: exactly one idle cycle in between.
      reset_pulse();
      cyc();
      d_write   = 1'b1;
      d_wmask   = 2'b11;
      d_address = 16'h0010;
      d_wdata   = 16'h1111;
      cyc();
      chk("b2b.first_write", mem_write, 1'b1);
      mem_resp = 1'b1;
      #1;
      chk("b2b.first_resp", d_resp, 1'b1);
      cyc();
      mem_resp  = 1'b0;
      d_address = 16'h0012;
      d_wdata   = 16'h2222;
      #1;
      chk("b2b.gap", {mem_read, mem_write, d_resp}, 3'b000);
      chk("b2b.gap_addr", mem_address, 16'h0000);
      cyc();
      chk("b2b.second_write", mem_write, 1'b1);
      chk("b2b.second_addr", mem_address, 16'h0012);
      mem_resp = 1'b1;
      #1;
      chk("b2b.second_resp", d_resp, 1'b1);
      cyc();
      clear_inputs();
      $display("transaction back_to_back_d done");

      // Reset while D owns the port; late mem_resp must be discarded.
      reset_pulse();
      cyc();
      d_read    = 1'b1;
      d_address = 16'h0A0A;
      cyc();
      chk("rst_mid.own_d", mem_read, 1'b1);
      rst = 1'b1;
      cyc();
      rst       = 1'b0;
      mem_resp  = 1'b1;
      mem_rdata = 16'h4321;
      #1;
      chk_all_zero("rst_mid");
      clear_inputs();
      $display("transaction reset_mid_d done");

      // D aborts its read; pending I is granted after one idle cycle.
      reset_pulse();
      cyc();
      d_read    = 1'b1;
      d_address = 16'h0200;
      i_read    = 1'b1;
      i_address = 16'h0040;
      cyc();
      chk("abort.d_owner", {mem_read, mem_address}, {1'b1, 16'h0200});
      cyc();
      d_read = 1'b0;
      #1;
      chk("abort.fall", {mem_read, d_resp}, 2'b00);
      cyc();
      chk("abort.idle", {mem_read, mem_address}, {1'b0, 16'h0000});
      cyc();
      chk("abort.i_owner", {mem_read, mem_address}, {1'b1, 16'h0040});
      mem_resp  = 1'b1;
      mem_rdata = 16'h5678;
      #1;
      chk("abort.i_resp", {i_resp, d_resp}, 2'b10);
      chk("abort.i_rdata", i_rdata, 16'h5678);
      cyc();
      clear_inputs();
      $display("transaction abort_d_then_i done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
